// File: rtl/fifo_pkg.sv
// Shared sizing constants for the dual-port-RAM streaming FIFO.
package fifo_pkg;
  localparam int DW       = 8;
  localparam int AW       = 7;
  localparam int DEPTH    = 2 ** AW;
  localparam int OQ_DEPTH = 2;

  typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/fifo_out_queue.sv
// Two-entry output queue that absorbs the RAM's registered read data.
module fifo_out_queue #(
  parameter int W = fifo_pkg::DW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         capture,
  input  logic [W-1:0] cap_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   oq_cnt
);
  import fifo_pkg::*;

  logic [W-1:0] slot0_r;
  logic [W-1:0] slot1_r;
  logic [1:0]   cnt_r;

  // Entry storage and occupancy; slot0 is always the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_r <= {W{1'b0}};
      slot1_r <= {W{1'b0}};
      cnt_r   <= 2'd0;
    end else begin
      case ({capture, pop})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            slot0_r <= cap_data;
            cnt_r   <= 2'd1;
          end else if (cnt_r == 2'd1) begin
            slot1_r <= cap_data;
            cnt_r   <= 2'd2;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        2'b01: begin
          if (cnt_r != 2'd0) begin
            slot0_r <= slot1_r;
            cnt_r   <= cnt_r - 2'd1;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        2'b11: begin
          // Simultaneous capture and pop keeps occupancy; new word lands behind the survivor.
          if (cnt_r == 2'(OQ_DEPTH)) begin
            slot0_r <= slot1_r;
            slot1_r <= cap_data;
          end else begin
            slot0_r <= cap_data;
            cnt_r   <= 2'd1;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign head   = slot0_r;
  assign oq_cnt = cnt_r;
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Streaming FIFO controller wrapped around an external 128x8 true dual-port RAM
// (port A writes, port B reads with one cycle of latency).
module dpram_fifo_ctrl #(
  parameter int DW    = fifo_pkg::DW,
  parameter int AW    = fifo_pkg::AW,
  parameter int DEPTH = fifo_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic [AW-1:0] ram_a1,
  output logic [DW-1:0] ram_d1,
  output logic          ram_wr1,
  output logic [AW-1:0] ram_a2,
  output logic [DW-1:0] ram_d2,
  output logic          ram_wr2,
  input  logic [DW-1:0] ram_q2
);
  import fifo_pkg::*;

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   ram_cnt_r;
  logic          rd_inflight_r;
  logic [1:0]    oq_cnt_s;
  logic          push_s;
  logic          pop_s;
  logic          issue_s;

  assign in_ready  = rst_n & (ram_cnt_r < (AW+1)'(DEPTH));
  assign push_s    = in_valid & in_ready;
  assign out_valid = (oq_cnt_s != 2'd0);
  assign pop_s     = out_valid & out_ready;

  // Read only when the queue plus the in-flight word leaves room after this cycle's pop.
  assign issue_s = (ram_cnt_r != {(AW+1){1'b0}}) &
                   (({1'b0, oq_cnt_s} + {2'b00, rd_inflight_r}) < (3'd2 + {2'b00, pop_s}));

  assign ram_a1  = wr_ptr_r;
  assign ram_d1  = in_data;
  assign ram_wr1 = push_s;
  assign ram_a2  = rd_ptr_r;
  assign ram_d2  = {DW{1'b0}};
  assign ram_wr2 = 1'b0;

  assign count = ram_cnt_r + (AW+1)'(rd_inflight_r) + (AW+1)'(oq_cnt_s);

  // Pointers, RAM occupancy and the read-in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      ram_cnt_r     <= {(AW+1){1'b0}};
      rd_inflight_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, issue_s})
        2'b10:   ram_cnt_r <= ram_cnt_r + (AW+1)'(1);
        2'b01:   ram_cnt_r <= ram_cnt_r - (AW+1)'(1);
        default: ram_cnt_r <= ram_cnt_r;
      endcase
      rd_inflight_r <= issue_s;
    end
  end

  fifo_out_queue #(.W(DW)) u_oq (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (rd_inflight_r),
    .cap_data (ram_q2),
    .pop      (pop_s),
    .head     (out_data),
    .oq_cnt   (oq_cnt_s)
  );
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural 128x8 dual-port RAM.
module tb_dpram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] count;
  logic [6:0] ram_a1;
  logic [7:0] ram_d1;
  logic       ram_wr1;
  logic [6:0] ram_a2;
  logic [7:0] ram_d2;
  logic       ram_wr2;
  logic [7:0] ram_q2;

  logic [7:0] mem [128];
  logic [7:0] exp_q [$];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .ram_a1(ram_a1), .ram_d1(ram_d1), .ram_wr1(ram_wr1), .ram_a2(ram_a2),
    .ram_d2(ram_d2), .ram_wr2(ram_wr2), .ram_q2(ram_q2)
  );

  // Behavioural RAM: port A writes, port B registered read.
  always @(posedge clk) begin
    if (ram_wr1) mem[ram_a1] <= ram_d1;
    if (ram_wr2) mem[ram_a2] <= ram_d2;
    ram_q2 <= mem[ram_a2];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Recorder: every accepted word becomes an expected output.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(in_data);
  end

  // Monitor: every consumed word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL out_unexpected: got %0h expected nothing", out_data);
      end else begin
        chk("out_data_order", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_empty(input string name);
    for (int n = 0; n < 400; n++) begin
      if (count == 8'd0 && !out_valid) break;
      step();
    end
    chk(name, {24'd0, count}, 32'd0);
    chk({name, "_sb"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wr1", {31'd0, ram_wr1}, 32'd0);
    chk("rst_count", {24'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ram_wr2_tied", {31'd0, ram_wr2}, 32'd0);
    chk("ram_d2_tied", {24'd0, ram_d2}, 32'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Single word latency
    in_valid = 1'b1; in_data = 8'hF0;
    #1;
    chk("single_wr1", {31'd0, ram_wr1}, 32'd1);
    chk("single_a1", {25'd0, ram_a1}, 32'd0);
    step();
    in_valid = 1'b0;
    chk("single_cnt_k", {24'd0, count}, 32'd1);
    chk("single_ov_k", {31'd0, out_valid}, 32'd0);
    step();
    chk("single_ov_k1", {31'd0, out_valid}, 32'd0);
    step();
    chk("single_ov_k2", {31'd0, out_valid}, 32'd1);
    chk("single_data", {24'd0, out_data}, 32'hF0);
    chk("single_cnt_k2", {24'd0, count}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_cnt_pop", {24'd0, count}, 32'd0);
    chk("single_ov_pop", {31'd0, out_valid}, 32'd0);

    // Streaming 0x00..0x3F with no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
      if (i >= 2) chk("stream_no_gap", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    step(); chk("stream_tail0", {31'd0, out_valid}, 32'd1);
    step(); chk("stream_tail1", {31'd0, out_valid}, 32'd1);
    step(); chk("stream_end_ov", {31'd0, out_valid}, 32'd0);
    chk("stream_end_cnt", {24'd0, count}, 32'd0);

    // Fill: 130 accepted, the 131st refused (write pointer starts at 65)
    out_ready = 1'b0;
    for (int i = 0; i < 131; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      chk("fill_in_ready", {31'd0, in_ready}, (i < 130) ? 32'd1 : 32'd0);
      if (i < 130) step();
    end
    chk("fill_count", {24'd0, count}, 32'd130);
    chk("fill_no_write", {31'd0, ram_wr1}, 32'd0);
    chk("fill_a1_held", {25'd0, ram_a1}, 32'd67);
    in_valid = 1'b0;

    // Partial drain then 0xAA past the wrap
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    chk("wrap_in_ready", {31'd0, in_ready}, 32'd1);
    chk("wrap_a1", {25'd0, ram_a1}, 32'd67);
    in_valid = 1'b1; in_data = 8'hAA;
    step();
    in_valid = 1'b0;
    chk("wrap_count", {24'd0, count}, 32'd130);
    chk("wrap_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    wait_empty("drain_full");

    // Backpressure toggling 1,0,0,1
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i);
      out_ready = pat[i % 4];
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_empty("bp_drain");

    // Reset mid-stream with five words held
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h50 + i);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("mid_count5", {24'd0, count}, 32'd5);
    rst_n = 1'b0;
    exp_q.delete();
    in_valid = 1'b1;
    #1;
    chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_cnt", {24'd0, count}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_wr1", {31'd0, ram_wr1}, 32'd0);
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = 8'h33;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    chk("post_rst_ov", {31'd0, out_valid}, 32'd1);
    chk("post_rst_first", {24'd0, out_data}, 32'h33);
    out_ready = 1'b1;
    wait_empty("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Control stage that sits directly upstream and downstream of the 128x8 true dual-port RAM and turns it into a streaming FIFO.
- Port A of the RAM is the write port: address a1, data d1, write enable wr1.
- Port B of the RAM is the read port: address a2, write enable wr2 held low, output q2.
- Valid/ready handshakes on the input and output sides; a 2-entry output queue hides the RAM's 1-cycle read latency so full throughput is kept.

Parameters:
- DW, 8, data width; equals the RAM word width.
- AW, 7, RAM address width.
- DEPTH, 128 (2**AW), number of RAM words; total FIFO capacity is DEPTH+2.

Ports:
- clk  in  1  rising-edge clock shared with the RAM.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DW  write data.
- in_valid  in  1  producer has data.
- in_ready  out  1  controller accepts data.
- out_data  out  DW  head-of-FIFO data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer takes the head word.
- count  out  AW+1  words held; includes RAM words, in-flight read and output queue.
- ram_a1  out  AW  RAM port A address (write pointer).
- ram_d1  out  DW  RAM port A data; equals in_data.
- ram_wr1  out  1  RAM port A write enable.
- ram_a2  out  AW  RAM port B address (read pointer).
- ram_d2  out  DW  tied to 0.
- ram_wr2  out  1  tied to 0.
- ram_q2  in  DW  RAM port B output; registered, valid the cycle after ram_a2 is sampled.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: wr_ptr=0, rd_ptr=0, ram_cnt=0, rd_inflight=0, oq_cnt=0, out_valid=0, count=0. While rst_n=0, in_ready=0 and ram_wr1=0.
- Reset asserted mid-operation discards all contents immediately; no RAM write may occur while rst_n=0.
- Push: push = in_valid & in_ready. in_ready = rst_n & (ram_cnt < DEPTH).
  - ram_wr1 = push (combinational); ram_a1 = wr_ptr.
  - On push, wr_ptr increments and wraps modulo 2**AW (127 -> 0).
- Issue (read request): issue = (ram_cnt != 0) & (oq_cnt + rd_inflight - pop < 2); ram_a2 = rd_ptr.
  - On issue, rd_ptr increments with wrap, and rd_inflight is set to 1 for the next cycle.
- Capture: if rd_inflight=1, ram_q2 is written into the output queue at the next edge.
- Pop: pop = out_valid & out_ready. out_data = queue head; out_valid = (oq_cnt != 0).
- Output queue: 2-entry FIFO. Simultaneous capture and pop are allowed at any oq_cnt, including 2.
- ram_cnt update: +1 on push only, -1 on issue only, unchanged on both or neither.
- count = ram_cnt + rd_inflight + oq_cnt.
- Read/write collision: a word becomes readable only after the edge that wrote it. The RAM therefore never sees a same-address read and write in the same cycle, and read-during-write behaviour is irrelevant.
- Latency: word accepted at edge k -> read issued at edge k+1 -> captured at edge k+2 -> out_valid high in the cycle after k+2 when the FIFO was empty.
- Steady state: push and pop may both occur every cycle with no bubbles.
- Full: ram_cnt=DEPTH forces in_ready=0. in_valid is then ignored; no write occurs and the pointer is unchanged.
- Empty: out_valid=0. out_ready is ignored and no state changes.
- Order: first in, first out, across all pointer wraps.

Decomposition:
- Shared package fifo_pkg holds DW, AW, DEPTH, and the output-queue depth constant OQ_DEPTH=2.
- One sub-module, fifo_out_queue: the 2-entry queue with inputs capture, cap_data, pop; outputs head, oq_cnt.
- The controller does not instantiate the RAM; the top level connects them.

Test Plan:
- Reset then single word: push 0xF0 at edge k -> ram_wr1=1 with ram_a1=0; out_valid rises after edge k+2 with out_data=0xF0; count goes 1 then 0 after pop.
- Streaming: push 0x00..0x3F back-to-back with out_ready=1 -> outputs appear in order, one per cycle, with no gaps after the initial 2-cycle latency.
- Fill: out_ready=0, push 131 words -> in_ready drops after 130 accepted (128 in RAM plus 2 queued); count=130; word 131 is not written.
- Drain full FIFO -> all 130 values emerge in order; pointer wrap 127 -> 0 is verified by pushing 0xAA as word 129 after partial drains.
- Backpressure toggling: out_ready pattern 1,0,0,1 during streaming -> no loss or duplication; oq_cnt never exceeds 2.
- Reset mid-stream: with count=5, pull rst_n low -> out_valid=0, count=0, in_ready=0 immediately; after release, push 0x33 -> out_data=0x33 is output first.
